// File: rtl/dnn_seq_ctrl_if.sv
// CPU-side op/write-back bus and neuron-side operand/handshake bus of the DNN sequencer.
// The slave modport is the sequencer's view; the master modport drives ops and models the neuron.
interface dnn_seq_ctrl_if;
  logic        op_valid;
  logic [1:0]  op_kind;
  logic        op_sel;
  logic [4:0]  op_rd;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic        neuron_ready;
  logic        neuron_done;
  logic [15:0] neuron_y;
  logic [15:0] x1;
  logic [15:0] x2;
  logic [15:0] x3;
  logic [15:0] w1;
  logic [15:0] w2;
  logic [15:0] w3;
  logic        neuron_start;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy;
  logic        err;

  modport slave (
    input  op_valid, op_kind, op_sel, op_rd, rd_a, rd_b,
    input  neuron_ready, neuron_done, neuron_y,
    output x1, x2, x3, w1, w2, w3, neuron_start,
    output stall, wb_en, wb_addr, wb_data, busy, err
  );

  modport master (
    output op_valid, op_kind, op_sel, op_rd, rd_a, rd_b,
    output neuron_ready, neuron_done, neuron_y,
    input  x1, x2, x3, w1, w2, w3, neuron_start,
    input  stall, wb_en, wb_addr, wb_data, busy, err
  );
endinterface

// File: rtl/dnn_seq_ctrl.sv
// DNN op sequencer: loads x/w operand lanes, launches a 3-input neuron on RUN,
// waits for its result with a 255-cycle timeout and writes it back to the register file.
module dnn_seq_ctrl (
  input  logic            clk,
  input  logic            rst,
  dnn_seq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ARM, WAIT, WB} state_t;

  localparam logic [1:0] OP_LDX = 2'd0;
  localparam logic [1:0] OP_LDW = 2'd1;
  localparam logic [1:0] OP_RUN = 2'd2;

  state_t      state_reg;
  logic [5:0]  loaded_reg;   // {W3, W2, W1, X3, X2, X1}
  logic [7:0]  cnt_reg;
  logic [15:0] x_reg [3];
  logic [15:0] w_reg [3];
  logic        start_reg;
  logic        active_reg;
  logic        wb_en_reg;
  logic [4:0]  wb_addr_reg;
  logic [31:0] wb_data_reg;
  logic        err_reg;

  function automatic logic [15:0] fmt(input logic [31:0] v);
    return {v[11:0], 4'b0000};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      loaded_reg  <= '0;
      cnt_reg     <= '0;
      for (int i = 0; i < 3; i++) begin
        x_reg[i] <= '0;
        w_reg[i] <= '0;
      end
      start_reg   <= 1'b0;
      active_reg  <= 1'b0;
      wb_en_reg   <= 1'b0;
      wb_addr_reg <= '0;
      wb_data_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      wb_en_reg <= 1'b0;
      err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.op_valid) begin
            case (bus.op_kind)
              OP_LDX: begin
                if (!bus.op_sel) begin
                  x_reg[0]        <= fmt(bus.rd_a);
                  x_reg[1]        <= fmt(bus.rd_b);
                  loaded_reg[1:0] <= 2'b11;
                end else begin
                  x_reg[2]      <= fmt(bus.rd_a);
                  loaded_reg[2] <= 1'b1;
                end
              end
              OP_LDW: begin
                if (!bus.op_sel) begin
                  w_reg[0]        <= fmt(bus.rd_a);
                  w_reg[1]        <= fmt(bus.rd_b);
                  loaded_reg[4:3] <= 2'b11;
                end else begin
                  w_reg[2]      <= fmt(bus.rd_a);
                  loaded_reg[5] <= 1'b1;
                end
              end
              OP_RUN: begin
                if (&loaded_reg) begin
                  state_reg   <= ARM;
                  active_reg  <= 1'b1;
                  wb_addr_reg <= bus.op_rd;
                end else begin
                  err_reg <= 1'b1;
                end
              end
              default: err_reg <= 1'b1;
            endcase
          end
        end
        ARM: begin
          if (bus.neuron_ready) begin
            start_reg <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          // Done is checked first so a result on the final cycle still gets written back.
          if (bus.neuron_done) begin
            wb_data_reg <= {16'h0000, bus.neuron_y};
            wb_en_reg   <= 1'b1;
            state_reg   <= WB;
          end else if (cnt_reg == 8'd254) begin
            err_reg    <= 1'b1;
            active_reg <= 1'b0;
            loaded_reg <= '0;
            state_reg  <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        WB: begin
          active_reg <= 1'b0;
          loaded_reg <= '0;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // stall and busy are the same condition (state != IDLE), kept in one register.
  assign bus.x1           = x_reg[0];
  assign bus.x2           = x_reg[1];
  assign bus.x3           = x_reg[2];
  assign bus.w1           = w_reg[0];
  assign bus.w2           = w_reg[1];
  assign bus.w3           = w_reg[2];
  assign bus.neuron_start = start_reg;
  assign bus.stall        = active_reg;
  assign bus.busy         = active_reg;
  assign bus.wb_en        = wb_en_reg;
  assign bus.wb_addr      = wb_addr_reg;
  assign bus.wb_data      = wb_data_reg;
  assign bus.err          = err_reg;

endmodule

// File: tb/tb_dnn_seq_ctrl.sv
// Scoreboard bench for dnn_seq_ctrl: expected err/start/write-back events are queued with
// their cycle stamps by the stimulus thread and popped by a monitor on each DUT event.
module tb_dnn_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  localparam int EV_ERR   = 0;
  localparam int EV_START = 1;
  localparam int EV_WB    = 2;

  typedef struct {
    int          ev;
    int          cyc;
    logic [36:0] data;
  } exp_t;

  exp_t exp_q[$];

  dnn_seq_ctrl_if dif ();

  dnn_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, expv);
    end else begin
      $display("ok   %s @cyc %0d: %0h", name, cyc, act);
    end
  endtask

  task automatic push_exp(input int ev, input int c, input logic [36:0] d);
    exp_t e;
    e.ev = ev; e.cyc = c; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic mon_event(input int ev, input logic [36:0] d);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: unexpected event %0d at cyc %0d data %0h", ev, cyc, d);
    end else begin
      e = exp_q.pop_front();
      if (e.ev != ev || e.cyc != cyc || e.data !== d) begin
        errors++;
        $display("FAIL event: got ev %0d cyc %0d data %0h expected ev %0d cyc %0d data %0h",
                 ev, cyc, d, e.ev, e.cyc, e.data);
      end else begin
        $display("ok   event %0d at cyc %0d data %0h", ev, cyc, d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dif.err)          mon_event(EV_ERR, 37'd0);
      if (dif.neuron_start) mon_event(EV_START, 37'd0);
      if (dif.wb_en)        mon_event(EV_WB, {dif.wb_addr, dif.wb_data});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] k, input logic s, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] b);
    dif.op_valid = 1'b1;
    dif.op_kind  = k;
    dif.op_sel   = s;
    dif.op_rd    = r;
    dif.rd_a     = a;
    dif.rd_b     = b;
    @(negedge clk);
    dif.op_valid = 1'b0;
  endtask

  task automatic load_all();
    issue(2'd0, 1'b0, 5'd0, 32'h100, 32'h200);
    issue(2'd0, 1'b1, 5'd0, 32'h300, 32'h0);
    issue(2'd1, 1'b0, 5'd0, 32'h400, 32'h500);
    issue(2'd1, 1'b1, 5'd0, 32'h600, 32'h0);
  endtask

  function automatic logic [159:0] all_outs();
    return {22'd0, dif.x1, dif.x2, dif.x3, dif.w1, dif.w2, dif.w3, dif.neuron_start,
            dif.stall, dif.wb_en, dif.wb_addr, dif.wb_data, dif.busy, dif.err};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    dif.op_valid = 1'b0; dif.op_kind = '0; dif.op_sel = 1'b0; dif.op_rd = '0;
    dif.rd_a = '0; dif.rd_b = '0;
    dif.neuron_ready = 1'b0; dif.neuron_done = 1'b0; dif.neuron_y = '0;

    tick(3);
    chk("reset_outputs", all_outs(), 160'd0);

    // First op accepted on the first edge after release
    rst = 1'b0;
    issue(2'd0, 1'b0, 5'd0, 32'h0000_0ABC, 32'h0000_0123);
    issue(2'd0, 1'b1, 5'd0, 32'h0000_0FFF, 32'h0);
    chk("x1_load", dif.x1, 16'hABC0);
    chk("x2_load", dif.x2, 16'h1230);
    chk("x3_load", dif.x3, 16'hFFF0);

    // RUN with only x lanes loaded, then reserved op
    push_exp(EV_ERR, cyc + 1, 37'd0);
    issue(2'd2, 1'b0, 5'd1, 32'h0, 32'h0);
    chk("norun_stall", dif.stall, 1'b0);
    chk("norun_x1", dif.x1, 16'hABC0);
    push_exp(EV_ERR, cyc + 1, 37'd0);
    issue(2'd3, 1'b0, 5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("rsvd_x2", dif.x2, 16'h1230);
    chk("rsvd_busy", dif.busy, 1'b0);

    // Overwrite x1/x2 (upper rd bits dropped), load w lanes
    issue(2'd0, 1'b0, 5'd0, 32'hFFFF_F5A5, 32'h0000_0123);
    issue(2'd1, 1'b0, 5'd0, 32'h0000_0111, 32'h0000_0222);
    issue(2'd1, 1'b1, 5'd0, 32'h0000_0333, 32'h0);
    chk("x1_overwrite", dif.x1, 16'h5A50);
    chk("w_lanes", {dif.w1, dif.w2, dif.w3}, {16'h1110, 16'h2220, 16'h3330});

    // Normal RUN, ready high, done 3 cycles after start
    dif.neuron_ready = 1'b1;
    c0 = cyc;
    push_exp(EV_START, c0 + 2, 37'd0);
    issue(2'd2, 1'b0, 5'd5, 32'h0, 32'h0);
    chk("run_stall", {dif.stall, dif.busy}, 2'b11);
    tick(1);
    // Load during WAIT must be ignored
    dif.op_valid = 1'b1; dif.op_kind = 2'd0; dif.op_sel = 1'b0; dif.rd_a = 32'h777; dif.rd_b = 32'h777;
    tick(1);
    dif.op_valid = 1'b0;
    chk("wait_stall", dif.stall, 1'b1);
    tick(2);
    dif.neuron_done = 1'b1; dif.neuron_y = 16'h1234;
    push_exp(EV_WB, c0 + 6, {5'd5, 32'h0000_1234});
    tick(1);
    dif.neuron_done = 1'b0;
    chk("wb_stall", dif.stall, 1'b1);
    tick(1);
    chk("post_wb_stall", dif.stall, 1'b0);
    chk("ignored_ld_x1", dif.x1, 16'h5A50);
    // Flags cleared: back-to-back RUN errors; stray done in IDLE does nothing
    push_exp(EV_ERR, cyc + 1, 37'd0);
    dif.neuron_done = 1'b1; dif.neuron_y = 16'hDEAD;
    issue(2'd2, 1'b0, 5'd6, 32'h0, 32'h0);
    dif.neuron_done = 1'b0;
    chk("b2b_stall", dif.stall, 1'b0);

    // Ready held low 10 cycles; done in the start-pulse cycle
    load_all();
    dif.neuron_ready = 1'b0;
    c0 = cyc;
    issue(2'd2, 1'b0, 5'd9, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      chk("arm_stall", dif.stall, 1'b1);
      tick(1);
    end
    dif.neuron_ready = 1'b1;
    push_exp(EV_START, c0 + 12, 37'd0);
    tick(1);
    dif.neuron_done = 1'b1; dif.neuron_y = 16'hBEEF;
    push_exp(EV_WB, c0 + 13, {5'd9, 32'h0000_BEEF});
    tick(1);
    dif.neuron_done = 1'b0;
    tick(1);
    chk("ready_end_stall", dif.stall, 1'b0);

    // Timeout: done never arrives
    load_all();
    c0 = cyc;
    push_exp(EV_START, c0 + 2, 37'd0);
    push_exp(EV_ERR, c0 + 257, 37'd0);
    issue(2'd2, 1'b0, 5'd3, 32'h0, 32'h0);
    tick(255);
    chk("timeout_pre_stall", dif.stall, 1'b1);
    tick(1);
    chk("timeout_stall", dif.stall, 1'b0);
    push_exp(EV_ERR, cyc + 1, 37'd0);
    issue(2'd2, 1'b0, 5'd3, 32'h0, 32'h0);

    // Reset during WAIT with done in the same cycle
    load_all();
    c0 = cyc;
    push_exp(EV_START, c0 + 2, 37'd0);
    issue(2'd2, 1'b0, 5'd7, 32'h0, 32'h0);
    tick(3);
    rst = 1'b1; dif.neuron_done = 1'b1; dif.neuron_y = 16'h5555;
    #1;
    chk("midrun_rst_outs", all_outs(), 160'd0);
    tick(1);
    chk("rst_hold_outs", all_outs(), 160'd0);
    rst = 1'b0; dif.neuron_done = 1'b0;
    issue(2'd0, 1'b0, 5'd0, 32'h0000_000A, 32'h0000_000B);
    chk("post_rst_ldx", {dif.x1, dif.x2}, {16'h00A0, 16'h00B0});

    tick(4);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
